sync_filter_bank: RTL and testbench

SYNC_FILTER_BANK -- requirements
Module: sync_filter_bank

---
 rtl/sync_pkg.sv | 21 ++
 rtl/sync_filter_chan.sv | 60 ++++++
 rtl/sync_filter_bank.sv | 37 +++
 tb/tb_sync_filter_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer/glitch-filter bank.
// Holds default depths and the counter-width function used by each channel.
package sync_pkg;

    localparam int DEF_NUM_STAGES    = 2;
    localparam int DEF_FILTER_CYCLES = 4;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: flop-chain synchronizer, stability counter, filtered level
// and registered rise/fall strobes.
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int   NUM_STAGES    = DEF_NUM_STAGES,
    parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter logic RST_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [NUM_STAGES-1:0] chain;
    logic [CNT_W-1:0]      count;
    logic                  s;
    logic                  differ;
    logic                  load;

    assign s      = chain[NUM_STAGES-1];
    assign differ = (s != level);
    assign load   = differ && (count == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {NUM_STAGES{RST_LEVEL}};
        end else begin
            chain <= {chain[NUM_STAGES-2:0], din};
        end
    end

    // A difference must persist FILTER_CYCLES samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            level <= RST_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= load && s;
            fall <= load && !s;
            if (load) begin
                level <= s;
                count <= '0;
            end else if (differ) begin
                count <= count + CNT_W'(1);
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of independent synchronize-and-debounce channels with edge strobes.
// Every output is registered except any_edge, which only ORs registered pulses.
module sync_filter_bank
    import sync_pkg::*;
#(
    parameter int                   BUS_WIDTH     = 8,
    parameter int                   NUM_STAGES    = DEF_NUM_STAGES,
    parameter int                   FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter logic [BUS_WIDTH-1:0] RST_VALUE     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] async_in,
    output logic [BUS_WIDTH-1:0] sync_out,
    output logic [BUS_WIDTH-1:0] rise_pulse,
    output logic [BUS_WIDTH-1:0] fall_pulse,
    output logic                 any_edge
);

    for (genvar g = 0; g < BUS_WIDTH; g++) begin : g_chan
        sync_filter_chan #(
            .NUM_STAGES    (NUM_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RST_LEVEL     (RST_VALUE[g])
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .din   (async_in[g]),
            .level (sync_out[g]),
            .rise  (rise_pulse[g]),
            .fall  (fall_pulse[g])
        );
    end

    assign any_edge = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: a default instance and a 3-stage/1-cycle/FF-reset
// instance, both compared every cycle against a sample-window reference model.
module tb_sync_filter_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in1, in2;
    logic [7:0] so1, rp1, fp1, so2, rp2, fp2;
    logic       ae1, ae2;

    always #5 clk = ~clk;

    sync_filter_bank dut1 (
        .clk(clk), .rst(rst), .async_in(in1),
        .sync_out(so1), .rise_pulse(rp1), .fall_pulse(fp1), .any_edge(ae1)
    );

    sync_filter_bank #(
        .BUS_WIDTH(8), .NUM_STAGES(3), .FILTER_CYCLES(1), .RST_VALUE(8'hFF)
    ) dut2 (
        .clk(clk), .rst(rst), .async_in(in2),
        .sync_out(so2), .rise_pulse(rp2), .fall_pulse(fp2), .any_edge(ae2)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference: output bit flips once the last FILTER_CYCLES synchronized
    // samples (taken since reset) all disagree with it; synchronized sample at
    // edge e is the input captured at edge e-NUM_STAGES, or the reset level.
    int         ns_of [2] = '{2, 3};
    int         fc_of [2] = '{4, 1};
    logic [7:0] rstv  [2] = '{8'h00, 8'hFF};
    logic [7:0] hist  [2][4096];
    int         ecnt  [2];
    logic [7:0] mout  [2];
    logic [7:0] mrise [2];
    logic [7:0] mfall [2];

    function automatic logic [7:0] sval(int d, int e);
        if (e - ns_of[d] >= 1) return hist[d][e - ns_of[d]];
        return rstv[d];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ecnt[d]  = 0;
            mout[d]  = rstv[d];
            mrise[d] = 8'h00;
            mfall[d] = 8'h00;
        end
    endtask

    task automatic model_edge(int d, logic [7:0] din);
        logic [7:0] nxt;
        logic [7:0] smp;
        bit         all;
        ecnt[d] = ecnt[d] + 1;
        hist[d][ecnt[d]] = din;
        nxt = mout[d];
        for (int i = 0; i < 8; i++) begin
            all = (ecnt[d] - fc_of[d] + 1 >= 1);
            for (int e = ecnt[d] - fc_of[d] + 1; e <= ecnt[d]; e++) begin
                smp = sval(d, e);
                if (e >= 1 && smp[i] == mout[d][i]) all = 0;
            end
            if (all) nxt[i] = ~mout[d][i];
        end
        mrise[d] = nxt & ~mout[d];
        mfall[d] = ~nxt & mout[d];
        mout[d]  = nxt;
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("so1", so1, mout[0]);
        chk("rp1", rp1, mrise[0]);
        chk("fp1", fp1, mfall[0]);
        chk("ae1", {7'b0, ae1}, {7'b0, |(mrise[0] | mfall[0])});
        chk("so2", so2, mout[1]);
        chk("rp2", rp2, mrise[1]);
        chk("fp2", fp2, mfall[1]);
        chk("ae2", {7'b0, ae2}, {7'b0, |(mrise[1] | mfall[1])});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge(0, in1);
        model_edge(1, in2);
        check_all();
    endtask

    // Assert reset between edges, check its immediate effect, release on a falling edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_so1", so1, 8'h00);
        chk("rst_so2", so2, 8'hFF);
        chk("rst_pulses", rp1 | fp1 | rp2 | fp2, 8'h00);
        chk("rst_any", {6'b0, ae1, ae2}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        in1 = 8'hFF;
        in2 = 8'hFF;
        #2;
        do_reset();

        // Power-up with all inputs high: six-edge latency, one-cycle rise strobe.
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 6) chk("up_hold", so1, 8'h00);
        end
        chk("up_so", so1, 8'hFF);
        chk("up_rise", rp1, 8'hFF);
        chk("up_any", {7'b0, ae1}, 8'h01);
        chk("up_nopulse2", {7'b0, ae2}, 8'h00);
        tick();
        chk("up_rise_off", rp1, 8'h00);

        // Single channel falls.
        in1 = 8'hF7;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) chk("fall_hold", so1, 8'hFF);
        end
        chk("fall_so", so1, 8'hF7);
        chk("fall_pulse", fp1, 8'h08);
        tick();
        chk("fall_off", fp1, 8'h00);

        // Three-cycle glitch on bit0 is filtered.
        in1 = 8'h00;
        repeat (8) tick();
        in1 = 8'h01;
        repeat (3) tick();
        in1 = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("glitch_so", so1, 8'h00);
            chk("glitch_any", {7'b0, ae1}, 8'h00);
        end

        // Reset mid-filter discards the partial count.
        in1 = 8'h04;
        repeat (3) tick();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("rel_nopulse2", {7'b0, ae2}, 8'h00);
            if (k < 6) chk("midrst_hold", so1, 8'h00);
        end
        chk("midrst_so", so1, 8'h04);
        chk("midrst_rise", rp1, 8'h04);

        // Three-stage, single-cycle filter instance.
        in2 = 8'h7F;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) chk("fc1_hold", so2, 8'hFF);
        end
        chk("fc1_so", so2, 8'h7F);
        chk("fc1_fall", fp2, 8'h80);

        // Bit1 toggling every cycle never passes.
        in1 = 8'h00;
        repeat (8) tick();
        for (int k = 0; k < 50; k++) begin
            in1[1] = ~in1[1];
            tick();
            chk("tog_so", so1 & 8'h02, 8'h00);
            chk("tog_pulse", (rp1 | fp1) & 8'h02, 8'h00);
        end

        // Random held levels of varying length, with a reset in the middle.
        for (int seg = 0; seg < 80; seg++) begin
            in1 = 8'($urandom);
            in2 = 8'($urandom);
            repeat ($urandom_range(1, 7)) tick();
            if (seg == 40) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
